// File: rtl/nspi_frame_seq.sv
// nspi_frame_seq: sequences one frame of multi-channel SPI words.
// A frame_start in IDLE drops spi_cs_n. For each word the sequencer reads
// the frame buffer (1-cycle read latency), loads the word for every channel
// into data_out, pulses start_tx and waits for a rising edge on tx_finish.
// After the last word it holds chip select for CS_HOLD cycles, then raises
// it and pulses frame_done.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_start       frame request, honoured only in IDLE
//   frame_busy        high from frame acceptance until DONE
//   frame_done        one-cycle pulse in the DONE cycle
//   rd_addr/rd_data   frame-buffer read port (data valid 1 cycle after addr)
//   start_tx          one-cycle pulse to the SPI transmitter
//   tx_finish         transmitter end-of-word (pulse or level)
//   data_out          per-channel word, stable from start_tx to next LOAD
//   spi_cs_n          shared active-low chip select
module nspi_frame_seq #(
  parameter int unsigned CHANNEL_NUMBER = 2,
  parameter int unsigned SPI_SIZE       = 8,
  parameter int unsigned FRAME_WORDS    = 384,
  parameter int unsigned ADDR_WIDTH     = $clog2(FRAME_WORDS),
  parameter int unsigned CS_SETUP       = 4,
  parameter int unsigned CS_HOLD        = 4,
  parameter int unsigned WORD_GAP       = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     frame_start,
  output logic                                     frame_busy,
  output logic                                     frame_done,
  output logic [ADDR_WIDTH-1:0]                    rd_addr,
  input  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  rd_data,
  output logic                                     start_tx,
  input  logic                                     tx_finish,
  output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_out,
  output logic                                     spi_cs_n
);

  // Delay counter holds (dwell - 1), so it must reach max(dwell) - 1.
  localparam int unsigned MAX_DLY_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MAX_DLY   = (MAX_DLY_A > WORD_GAP) ? MAX_DLY_A : WORD_GAP;
  localparam int unsigned CNT_W     = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SETUP = 4'd1,
    FETCH = 4'd2,
    LOAD  = 4'd3,
    START = 4'd4,
    WAIT  = 4'd5,
    GAP   = 4'd6,
    HOLD  = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        dly_cnt;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    tx_prev;
  logic                    tx_rise_c;

  // Edge detect makes a held-high finish count once per word.
  assign tx_rise_c = tx_finish & ~tx_prev;

  // Frame sequencer with registered outputs. rd_addr is set on the way
  // into FETCH and start_tx on the way out of START, which places the
  // start_tx pulse exactly 3 cycles after FETCH entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      word_idx   <= '0;
      tx_prev    <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      rd_addr    <= '0;
      start_tx   <= 1'b0;
      data_out   <= '0;
      spi_cs_n   <= 1'b1;
    end else begin
      tx_prev    <= tx_finish;
      start_tx   <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            frame_busy <= 1'b1;
            spi_cs_n   <= 1'b0;
            word_idx   <= '0;
            if (CS_SETUP > 0) begin
              state   <= SETUP;
              dly_cnt <= SETUP_LOAD;
            end else begin
              state   <= FETCH;
              rd_addr <= '0;
            end
          end
        end

        SETUP: begin
          if (dly_cnt == '0) begin
            state   <= FETCH;
            rd_addr <= word_idx;
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        FETCH: state <= LOAD;

        LOAD: begin
          data_out <= rd_data;
          state    <= START;
        end

        START: begin
          start_tx <= 1'b1;
          state    <= WAIT;
        end

        WAIT: begin
          if (tx_rise_c) begin
            if (word_idx == LAST_IDX) begin
              if (CS_HOLD > 0) begin
                state   <= HOLD;
                dly_cnt <= HOLD_LOAD;
              end else begin
                state      <= DONE;
                spi_cs_n   <= 1'b1;
                frame_done <= 1'b1;
                frame_busy <= 1'b0;
              end
            end else begin
              word_idx <= word_idx + ADDR_WIDTH'(1);
              if (WORD_GAP > 0) begin
                state   <= GAP;
                dly_cnt <= GAP_LOAD;
              end else begin
                state   <= FETCH;
                rd_addr <= word_idx + ADDR_WIDTH'(1);
              end
            end
          end
        end

        GAP: begin
          if (dly_cnt == '0) begin
            state   <= FETCH;
            rd_addr <= word_idx;
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          if (dly_cnt == '0) begin
            state      <= DONE;
            spi_cs_n   <= 1'b1;
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        // frame_start is not sampled here, so a request coincident with
        // frame_done is dropped.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nspi_frame_seq.sv
// Scoreboard bench for nspi_frame_seq (2 channels, 4-word frame).
module tb_nspi_frame_seq;

  localparam int unsigned CH    = 2;
  localparam int unsigned SZ    = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned SETUP = 4;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAPC  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    frame_start;
  logic                    frame_busy;
  logic                    frame_done;
  logic [AW-1:0]           rd_addr;
  logic [CH-1:0][SZ-1:0]   rd_data;
  logic                    start_tx;
  logic                    tx_finish;
  logic [CH-1:0][SZ-1:0]   data_out;
  logic                    spi_cs_n;

  nspi_frame_seq #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .FRAME_WORDS(WORDS),
    .CS_SETUP(SETUP), .CS_HOLD(HOLD), .WORD_GAP(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_busy(frame_busy),
    .frame_done(frame_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .start_tx(start_tx), .tx_finish(tx_finish), .data_out(data_out),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer with 1-cycle read latency.
  logic [CH-1:0][SZ-1:0] mem [WORDS];
  initial begin
    mem[0][0] = 8'h0F; mem[0][1] = 8'hF0;
    mem[1][0] = 8'h11; mem[1][1] = 8'h22;
    mem[2][0] = 8'hBB; mem[2][1] = 8'hCC;
    mem[3][0] = 8'h55; mem[3][1] = 8'hAA;
  end
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Expected {ch1, ch0} words, in send order.
  logic [15:0] exp_word [WORDS] = '{16'hF00F, 16'h2211, 16'hCCBB, 16'hAA55};

  typedef struct {
    int unsigned idx;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: finish after tx_delay cycles, held tx_len cycles,
  // optionally followed by a spurious pulse landing in GAP/HOLD.
  int tx_delay = 4;
  int tx_len   = 1;
  bit tx_spur  = 1'b0;
  int fin_cyc  = 0;
  initial begin
    tx_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (start_tx) begin
        repeat (tx_delay) @(negedge clk);
        tx_finish = 1'b1;
        fin_cyc   = cyc;
        repeat (tx_len) @(negedge clk);
        tx_finish = 1'b0;
        if (tx_spur) begin
          @(negedge clk);
          tx_finish = 1'b1;
          @(negedge clk);
          tx_finish = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every start_tx and records timing.
  int n_start = 0;
  int n_done = 0;
  int cs_falls = 0;
  int cs_rises = 0;
  int cs_fall_cyc = 0;
  int cs_rise_cyc = 0;
  int first_start_cyc = -1;
  bit cs_prev = 1'b1;
  always @(negedge clk) begin
    if (cs_prev && !spi_cs_n) begin
      cs_falls++;
      cs_fall_cyc = cyc;
      first_start_cyc = -1;
    end
    if (!cs_prev && spi_cs_n) begin
      cs_rises++;
      cs_rise_cyc = cyc;
    end
    cs_prev = spi_cs_n;
    if (start_tx) begin
      exp_t e;
      n_start++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_start_tx", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("rd_addr", 32'(rd_addr), e.idx);
      end
    end
    if (frame_done) n_done++;
  end

  task automatic push_frame();
    for (int i = 0; i < int'(WORDS); i++) begin
      exp_t e;
      e.idx  = i;
      e.data = exp_word[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 2000);
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int k;
    k = 0;
    while (n_start < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("start_count_reached", 32'(n_start >= target), 32'd1);
  endtask

  task automatic clear_stats();
    n_start = 0; n_done = 0; cs_falls = 0; cs_rises = 0;
  endtask

  task automatic check_frame(input string tag, input int starts, input int dones);
    repeat (3) @(negedge clk);
    check({tag, "_starts"}, 32'(n_start), 32'(starts));
    check({tag, "_dones"}, 32'(n_done), 32'(dones));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_low"}, 32'(frame_busy), 32'd0);
    check({tag, "_cs_high"}, 32'(spi_cs_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int done_before;
    rst = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_start_tx", 32'(start_tx), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame plus chip-select timing. Setup seen at the pins is the
    // SETUP dwell plus the 3-cycle fetch pipeline.
    tx_delay = 4; tx_len = 1; tx_spur = 1'b0;
    clear_stats();
    push_frame();
    launch();
    check("t1_busy", 32'(frame_busy), 32'd1);
    wait_done("t1_done");
    check_frame("t1", 4, 1);
    check("t1_cs_setup", 32'(first_start_cyc - cs_fall_cyc), 32'(SETUP + 3));
    check("t1_cs_hold", 32'(cs_rise_cyc - fin_cyc), 32'(HOLD + 1));
    check("t1_cs_falls", 32'(cs_falls), 32'd1);
    check("t1_cs_rises", 32'(cs_rises), 32'd1);

    // Level finish held 5 cycles.
    tx_delay = 3; tx_len = 5; tx_spur = 1'b0;
    clear_stats();
    push_frame();
    launch();
    wait_done("t2_done");
    check_frame("t2", 4, 1);
    check("t2_cs_hold", 32'(cs_rise_cyc - fin_cyc), 32'(HOLD + 1));

    // Spurious finish pulse after each word.
    tx_delay = 2; tx_len = 1; tx_spur = 1'b1;
    clear_stats();
    push_frame();
    launch();
    wait_done("t3_done");
    check_frame("t3", 4, 1);
    check("t3_cs_falls", 32'(cs_falls), 32'd1);
    tx_spur = 1'b0;
    repeat (4) @(negedge clk);

    // frame_start during WAIT and coincident with frame_done is ignored;
    // one cycle later it starts a fresh frame.
    tx_delay = 1; tx_len = 2;
    clear_stats();
    push_frame();
    launch();
    wait_starts(1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("t4_done_a");
    done_at = cyc;
    push_frame();
    frame_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    check("t4_busy_second", 32'(frame_busy), 32'd1);
    wait_done("t4_done_b");
    check_frame("t4", 8, 2);
    check("t4_second_cs_fall", 32'(cs_fall_cyc - done_at), 32'd2);

    // Reset during WAIT of word 2 aborts at once; next frame starts at 0.
    tx_delay = 6; tx_len = 1;
    clear_stats();
    push_frame();
    launch();
    wait_starts(3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_cs_n", 32'(spi_cs_n), 32'd1);
    check("t5_start_tx", 32'(start_tx), 32'd0);
    check("t5_busy", 32'(frame_busy), 32'd0);
    check("t5_done", 32'(frame_done), 32'd0);
    check("t5_rd_addr", 32'(rd_addr), 32'd0);
    check("t5_data_out", 32'(data_out), 32'd0);
    exp_q.delete();
    done_before = n_done;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_no_done", 32'(n_done), 32'(done_before));
    clear_stats();
    push_frame();
    launch();
    wait_done("t5_done_after");
    check_frame("t5", 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
